// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and types for the multi-channel clock divider.
package clk_div_pkg;
    localparam int MIN_DIV = 2;
    localparam int DIV_W = 8;
    localparam int RST_DIV = 12;
    typedef logic [DIV_W-1:0] div_t;
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with a shadowed divisor applied only at period boundaries.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DIV_W,
    parameter int DEF_DIV = RST_DIV
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pending,
    output logic             clk_out,
    output logic             rise_stb
);
    logic [CNT_W-1:0] div_q, div_d, cnt_q, cnt_d, shd_q, shd_d;
    logic pend_q, pend_d, clk_q, clk_d, stb_q, stb_d, wrap;

    assign wrap = cnt_q == div_q - 1'b1;

    always_comb begin
        div_d = div_q;
        shd_d = shd_q;
        pend_d = pend_q;
        clk_d = 1'b0;
        stb_d = 1'b0;
        // The old shadow is applied before a same-cycle write lands, so that write waits a period.
        if (pend_q && (!en || sync || wrap)) begin
            div_d = shd_q;
            pend_d = 1'b0;
        end
        if (!en) begin
            cnt_d = div_d - 1'b1;
        end else begin
            cnt_d = (sync || wrap) ? '0 : cnt_q + 1'b1;
            clk_d = cnt_d < (div_d >> 1);
            stb_d = cnt_d == '0;
        end
        if (wr) begin
            shd_d = wr_div;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= CNT_W'(DEF_DIV);
            cnt_q <= CNT_W'(DEF_DIV - 1);
            shd_q <= '0;
            pend_q <= 1'b0;
            clk_q <= 1'b0;
            stb_q <= 1'b0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            shd_q <= shd_d;
            pend_q <= pend_d;
            clk_q <= clk_d;
            stb_q <= stb_d;
        end
    end

    assign pending = pend_q;
    assign clk_out = clk_q;
    assign rise_stb = stb_q;
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: N_CH programmable clock dividers sharing one config port and a global sync.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CNT_W = DIV_W,
    parameter int DEF_DIV = RST_DIV,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             cfg_valid,
    input  logic [CH_W-1:0]  cfg_chan,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  rise_stb
);
    logic [N_CH-1:0] pend, wr;
    logic chan_ok, acc, bad, cfg_err_d, cfg_err_q;

    always_comb begin
        chan_ok = 32'(cfg_chan) < N_CH;
        // An out-of-range channel keeps ready high so its error is always reported.
        cfg_ready = !chan_ok || !(|(pend & (N_CH'(1) << cfg_chan)));
        acc = cfg_valid && cfg_ready;
        bad = acc && (!chan_ok || cfg_div < CNT_W'(MIN_DIV));
        wr = (acc && !bad) ? N_CH'(1) << cfg_chan : '0;
        cfg_err_d = bad;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cfg_err_q <= 1'b0;
        else cfg_err_q <= cfg_err_d;
    end

    assign cfg_err = cfg_err_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_div_chan #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .en       (en[i]),
            .sync     (sync),
            .wr       (wr[i]),
            .wr_div   (cfg_div),
            .pending  (pend[i]),
            .clk_out  (clk_out[i]),
            .rise_stb (rise_stb[i])
        );
    end
endmodule
